// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbitration slice.
//
// Contents:
//   UART_BYTE_W  width of one transmitted byte
//   ARB .. WAIT_IDLE  arbiter FSM state encodings
//   ptrWidth()   width of an index into n requesters, never less than 1
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    // Arbiter FSM state encodings.
    localparam logic [2:0] ARB       = 3'd0;
    localparam logic [2:0] HOLD      = 3'd1;
    localparam logic [2:0] ISSUE     = 3'd2;
    localparam logic [2:0] WAIT_BUSY = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;
    localparam logic [2:0] WAIT_IDLE = 3'd5;

    // A single requester still needs a 1-bit pointer.
    function automatic int ptrWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Grants the first asserted request at or after the pointer, wrapping
// modulo NUM_REQ.
//
// Ports:
//   i_Req    in   NUM_REQ  request vector
//   i_Ptr    in   PTR_W    index with highest priority this pick
//   o_Grant  out  NUM_REQ  one-hot grant, all zero when no request
//   o_Any    out  1        at least one request is asserted
module rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = ptrWidth(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_Req,
    input  logic [PTR_W-1:0]   i_Ptr,
    output logic [NUM_REQ-1:0] o_Grant,
    output logic               o_Any
);

    logic             w_Found;
    int               w_Idx;
    logic [PTR_W-1:0] w_Sel;

    // Walk the requests starting at the pointer; the first hit wins.
    always_comb begin
        o_Grant = '0;
        o_Any   = |i_Req;
        w_Found = 1'b0;
        w_Idx   = 0;
        w_Sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_Idx = int'(i_Ptr) + i;
            if (w_Idx >= NUM_REQ) begin
                w_Idx = w_Idx - NUM_REQ;
            end
            w_Sel = PTR_W'(w_Idx);
            if (!w_Found && i_Req[w_Sel]) begin
                o_Grant[w_Sel] = 1'b1;
                w_Found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one serial UART transmitter between NUM_REQ byte-stream sources.
// Ownership rotates round-robin per packet. The owner keeps the transmitter
// until it hands over a byte flagged last, or until it leaves the grant
// unused for GRANT_TIMEOUT clocks (0 disables that timeout). Each byte is
// started only after the previous one has fully finished (Active low and
// Done low).
//
// Ports:
//   i_Clock      in   1          system clock
//   i_Reset      in   1          synchronous active-high reset
//   i_Req_Valid  in   NUM_REQ    per-requester byte valid
//   i_Req_Byte   in   8*NUM_REQ  requester k on bits [8k+7:8k]
//   i_Req_Last   in   NUM_REQ    byte ends its packet
//   o_Req_Ready  out  NUM_REQ    byte taken when Ready & Valid
//   o_Grant      out  NUM_REQ    one-hot current owner, zero when none
//   o_Tx_DV      out  1          one-cycle start strobe to transmitter
//   o_Tx_Byte    out  8          byte to transmitter, stable DV..Done
//   i_Tx_Active  in   1          transmitter busy
//   i_Tx_Done    in   1          transmitter finished (may last >1 cycle)
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int GRANT_TIMEOUT = 1024,
    parameter int TIMER_W       = 16
) (
    input  logic                           i_Clock,
    input  logic                           i_Reset,
    input  logic [NUM_REQ-1:0]             i_Req_Valid,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] i_Req_Byte,
    input  logic [NUM_REQ-1:0]             i_Req_Last,
    output logic [NUM_REQ-1:0]             o_Req_Ready,
    output logic [NUM_REQ-1:0]             o_Grant,
    output logic                           o_Tx_DV,
    output logic [UART_BYTE_W-1:0]         o_Tx_Byte,
    input  logic                           i_Tx_Active,
    input  logic                           i_Tx_Done
);

    localparam int                PTR_W      = ptrWidth(NUM_REQ);
    localparam bit                TIMEOUT_EN = (GRANT_TIMEOUT != 0);
    localparam logic [TIMER_W-1:0] TIMER_LAST =
        TIMEOUT_EN ? TIMER_W'(GRANT_TIMEOUT - 1) : '0;

    logic [2:0]             r_State;
    logic [NUM_REQ-1:0]     r_Grant;
    logic [PTR_W-1:0]       r_Ptr;
    logic [TIMER_W-1:0]     r_Timer;
    logic [UART_BYTE_W-1:0] r_TxByte;
    logic                   r_Last;

    logic [NUM_REQ-1:0]     w_PickGrant;
    logic                   w_AnyReq;
    logic                   w_TxIdle;
    logic [PTR_W-1:0]       w_GrantIdx;
    logic [PTR_W-1:0]       w_NextPtr;
    logic [UART_BYTE_W-1:0] w_SelByte;
    logic                   w_SelLast;
    logic                   w_Accept;
    logic                   w_TimedOut;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .i_Req   (i_Req_Valid),
        .i_Ptr   (r_Ptr),
        .o_Grant (w_PickGrant),
        .o_Any   (w_AnyReq)
    );

    // Decode the one-hot owner into an index and route its byte/last flag.
    always_comb begin
        w_GrantIdx = '0;
        w_SelByte  = '0;
        w_SelLast  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_Grant[k]) begin
                w_GrantIdx = PTR_W'(k);
                w_SelByte  = i_Req_Byte[k*UART_BYTE_W +: UART_BYTE_W];
                w_SelLast  = i_Req_Last[k];
            end
        end
    end

    // Next pointer is owner+1, wrapped explicitly so non-power-of-two
    // requester counts still rotate correctly.
    always_comb begin
        w_NextPtr  = (w_GrantIdx == PTR_W'(NUM_REQ - 1)) ? '0 : w_GrantIdx + PTR_W'(1);
        w_TxIdle   = !i_Tx_Active && !i_Tx_Done;
        w_Accept   = |(i_Req_Valid & r_Grant);
        w_TimedOut = TIMEOUT_EN && (r_Timer == TIMER_LAST);
    end

    // Outputs are pure decodes of registered state.
    always_comb begin
        o_Req_Ready = (r_State == HOLD) ? r_Grant : '0;
        o_Grant     = r_Grant;
        o_Tx_DV     = (r_State == ISSUE);
        o_Tx_Byte   = r_TxByte;
    end

    // Arbiter FSM. A reset abandons any transfer in flight; ARB refuses to
    // grant while the transmitter is still finishing a byte, which also
    // covers the frame left running by a mid-transfer reset.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_State  <= ARB;
            r_Grant  <= '0;
            r_Ptr    <= '0;
            r_Timer  <= '0;
            r_TxByte <= '0;
            r_Last   <= 1'b0;
        end else begin
            case (r_State)
                ARB: begin
                    if (w_AnyReq && w_TxIdle) begin
                        r_Grant <= w_PickGrant;
                        r_Timer <= '0;
                        r_State <= HOLD;
                    end
                end
                HOLD: begin
                    // An accept wins over a timeout expiring in the same cycle.
                    if (w_Accept) begin
                        r_TxByte <= w_SelByte;
                        r_Last   <= w_SelLast;
                        r_Timer  <= '0;
                        r_State  <= ISSUE;
                    end else if (w_TimedOut) begin
                        r_Grant <= '0;
                        r_Ptr   <= w_NextPtr;
                        r_Timer <= '0;
                        r_State <= ARB;
                    end else begin
                        r_Timer <= r_Timer + 1'b1;
                    end
                end
                ISSUE: begin
                    r_State <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (i_Tx_Active) begin
                        r_State <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (i_Tx_Done) begin
                        r_State <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    // Done may be held for several cycles; wait until it
                    // falls so the same byte cannot trigger a second issue.
                    if (w_TxIdle) begin
                        if (r_Last) begin
                            r_Grant <= '0;
                            r_Ptr   <= w_NextPtr;
                            r_State <= ARB;
                        end else begin
                            r_State <= HOLD;
                        end
                    end
                end
                default: begin
                    r_State <= ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NUM_REQ=4, GRANT_TIMEOUT=16).
// A behavioural transmitter model (4 clocks per bit, 10-bit frames) answers
// the DV strobe with Active then Done. Expected (grant, byte) pairs are
// queued by the stimulus and popped by a monitor on every DV.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ       = 4;
    localparam int GRANT_TIMEOUT = 16;
    localparam int TIMER_W       = 16;
    localparam int CLKS_PER_BIT  = 4;
    localparam int FRAME_BITS    = 10;

    logic                   i_Clock = 1'b0;
    logic                   i_Reset;
    logic [NUM_REQ-1:0]     i_Req_Valid;
    logic [8*NUM_REQ-1:0]   i_Req_Byte;
    logic [NUM_REQ-1:0]     i_Req_Last;
    logic [NUM_REQ-1:0]     o_Req_Ready;
    logic [NUM_REQ-1:0]     o_Grant;
    logic                   o_Tx_DV;
    logic [7:0]             o_Tx_Byte;
    logic                   i_Tx_Active;
    logic                   i_Tx_Done;

    always #5 i_Clock = ~i_Clock;

    uart_tx_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .GRANT_TIMEOUT (GRANT_TIMEOUT),
        .TIMER_W       (TIMER_W)
    ) dut (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_Req_Valid (i_Req_Valid),
        .i_Req_Byte  (i_Req_Byte),
        .i_Req_Last  (i_Req_Last),
        .o_Req_Ready (o_Req_Ready),
        .o_Grant     (o_Grant),
        .o_Tx_DV     (o_Tx_DV),
        .o_Tx_Byte   (o_Tx_Byte),
        .i_Tx_Active (i_Tx_Active),
        .i_Tx_Done   (i_Tx_Done)
    );

    typedef struct packed {
        logic [3:0] grant;
        logic [7:0] data;
    } sbEntry_t;

    int         total = 0;
    int         bad = 0;
    int         dvCount = 0;
    int         doneCycles = 1;
    int         idleHoldCount = 0;
    bit         resetInFrame = 1'b0;
    sbEntry_t   sbQ[$];
    logic [8:0] reqQ[NUM_REQ][$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Queue one byte on requester req's input stream.
    task automatic applyStimulus(input int req, input logic [7:0] data, input logic last);
        reqQ[req].push_back({last, data});
    endtask

    task automatic expectTx(input logic [3:0] grant, input logic [7:0] data);
        sbQ.push_back('{grant: grant, data: data});
    endtask

    task automatic resetDut(input string name);
        i_Reset = 1'b1;
        repeat (2) @(negedge i_Clock);
        checkOutput({name, " reset grant"}, o_Grant, 0);
        checkOutput({name, " reset ready"}, o_Req_Ready, 0);
        checkOutput({name, " reset dv"}, o_Tx_DV, 0);
        checkOutput({name, " reset byte"}, o_Tx_Byte, 0);
        dvCount       = 0;
        idleHoldCount = 0;
        i_Reset       = 1'b0;
    endtask

    task automatic waitDv(input int target, input int budget, input string name);
        int n = 0;
        while (dvCount < target && n < budget) begin
            @(negedge i_Clock);
            n++;
        end
        checkOutput({name, " dv reached"}, (dvCount >= target), 1);
    endtask

    task automatic waitTxIdle(input int budget, input string name);
        int n = 0;
        repeat (2) @(negedge i_Clock);
        while ((i_Tx_Active || i_Tx_Done) && n < budget) begin
            @(negedge i_Clock);
            n++;
        end
        checkOutput({name, " tx idle reached"}, (!i_Tx_Active && !i_Tx_Done), 1);
    endtask

    // Requester drivers: present the head of each queue, pop it when the
    // previous edge saw Ready & Valid.
    initial begin
        logic [NUM_REQ-1:0] acc;
        logic [8:0]         head;
        i_Req_Valid = '0;
        i_Req_Byte  = '0;
        i_Req_Last  = '0;
        forever begin
            @(posedge i_Clock);
            acc = o_Req_Ready & i_Req_Valid;
            #1;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (acc[k] && reqQ[k].size() > 0) void'(reqQ[k].pop_front());
                if (reqQ[k].size() > 0) begin
                    head                = reqQ[k][0];
                    i_Req_Valid[k]      = 1'b1;
                    i_Req_Byte[k*8 +: 8] = head[7:0];
                    i_Req_Last[k]       = head[8];
                end else begin
                    i_Req_Valid[k]      = 1'b0;
                    i_Req_Byte[k*8 +: 8] = 8'h00;
                    i_Req_Last[k]       = 1'b0;
                end
            end
        end
    end

    // Transmitter model: not affected by i_Reset, so a frame in flight
    // keeps running across a DUT reset.
    initial begin
        logic [7:0] txData;
        bit         stableOk;
        i_Tx_Active = 1'b0;
        i_Tx_Done   = 1'b0;
        forever begin
            @(posedge i_Clock);
            if (o_Tx_DV === 1'b1) begin
                txData       = o_Tx_Byte;
                stableOk     = 1'b1;
                resetInFrame = 1'b0;
                #1 i_Tx_Active = 1'b1;
                repeat (CLKS_PER_BIT * FRAME_BITS) begin
                    @(posedge i_Clock);
                    if (i_Reset) resetInFrame = 1'b1;
                    if (!resetInFrame && o_Tx_Byte !== txData) stableOk = 1'b0;
                end
                #1;
                i_Tx_Active = 1'b0;
                i_Tx_Done   = 1'b1;
                repeat (doneCycles) begin
                    @(posedge i_Clock);
                    if (i_Reset) resetInFrame = 1'b1;
                    if (!resetInFrame && o_Tx_Byte !== txData) stableOk = 1'b0;
                end
                #1 i_Tx_Done = 1'b0;
                if (!resetInFrame) checkOutput("tx byte stable DV..Done", stableOk, 1);
            end
        end
    end

    // Monitor: every DV pops the scoreboard and checks owner, byte and
    // that the transmitter was idle.
    initial begin
        sbEntry_t exp;
        forever begin
            @(negedge i_Clock);
            if (o_Req_Ready == 4'b0010 && !i_Req_Valid[1]) idleHoldCount++;
            if (o_Tx_DV === 1'b1) begin
                dvCount++;
                checkOutput("dv while tx busy", {i_Tx_Active, i_Tx_Done}, 0);
                if (sbQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected dv: byte 0x%0h grant 0x%0h with nothing expected",
                             o_Tx_Byte, o_Grant);
                end else begin
                    exp = sbQ.pop_front();
                    checkOutput("grant at dv", o_Grant, exp.grant);
                    checkOutput("byte at dv", o_Tx_Byte, exp.data);
                end
            end
        end
    end

    initial begin
        int  n;
        bit  sawGrant;
        i_Reset = 1'b1;

        // Single requester, two-byte packet.
        resetDut("single");
        applyStimulus(2, 8'hA5, 1'b0);
        applyStimulus(2, 8'h3C, 1'b1);
        expectTx(4'b0100, 8'hA5);
        expectTx(4'b0100, 8'h3C);
        waitDv(2, 200, "single");
        waitTxIdle(200, "single");
        checkOutput("single grant held until idle seen", o_Grant, 4'b0100);
        @(negedge i_Clock);
        checkOutput("single grant released", o_Grant, 4'b0000);

        // Contention: all four valid from reset, one-byte packets.
        i_Reset = 1'b1;
        applyStimulus(0, 8'h10, 1'b1);
        applyStimulus(1, 8'h21, 1'b1);
        applyStimulus(2, 8'h32, 1'b1);
        applyStimulus(3, 8'h43, 1'b1);
        expectTx(4'b0001, 8'h10);
        expectTx(4'b0010, 8'h21);
        expectTx(4'b0100, 8'h32);
        expectTx(4'b1000, 8'h43);
        resetDut("contention");
        waitDv(4, 400, "contention");
        waitTxIdle(200, "contention");
        repeat (4) @(negedge i_Clock);
        checkOutput("contention dv count", dvCount, 4);

        // Fairness: requester 0 back-to-back against waiting requester 3.
        i_Reset = 1'b1;
        applyStimulus(0, 8'h01, 1'b1);
        applyStimulus(0, 8'h02, 1'b1);
        applyStimulus(3, 8'h30, 1'b1);
        applyStimulus(3, 8'h31, 1'b1);
        expectTx(4'b0001, 8'h01);
        expectTx(4'b1000, 8'h30);
        expectTx(4'b0001, 8'h02);
        expectTx(4'b1000, 8'h31);
        resetDut("fairness");
        waitDv(4, 400, "fairness");
        waitTxIdle(200, "fairness");
        checkOutput("fairness dv count", dvCount, 4);

        // Timeout: requester 1 stalls mid-packet, requester 2 takes over.
        i_Reset = 1'b1;
        applyStimulus(1, 8'h11, 1'b0);
        applyStimulus(2, 8'h22, 1'b1);
        expectTx(4'b0010, 8'h11);
        expectTx(4'b0100, 8'h22);
        resetDut("timeout");
        waitDv(2, 300, "timeout");
        waitTxIdle(200, "timeout");
        checkOutput("timeout idle HOLD cycles", idleHoldCount, GRANT_TIMEOUT);

        // Last byte arriving on the final HOLD cycle before expiry.
        i_Reset = 1'b1;
        applyStimulus(1, 8'h11, 1'b0);
        applyStimulus(2, 8'h22, 1'b1);
        expectTx(4'b0010, 8'h11);
        expectTx(4'b0010, 8'h12);
        expectTx(4'b0100, 8'h22);
        resetDut("expiry edge");
        n = 0;
        while (idleHoldCount < GRANT_TIMEOUT - 1 && n < 300) begin
            @(negedge i_Clock);
            #1;
            n++;
        end
        checkOutput("expiry edge reached last idle cycle", idleHoldCount, GRANT_TIMEOUT - 1);
        applyStimulus(1, 8'h12, 1'b1);
        waitDv(3, 300, "expiry edge");
        waitTxIdle(200, "expiry edge");
        checkOutput("expiry edge idle HOLD cycles", idleHoldCount, GRANT_TIMEOUT - 1);

        // Handshake with a three-cycle Done pulse.
        doneCycles = 3;
        i_Reset = 1'b1;
        applyStimulus(0, 8'h5A, 1'b0);
        applyStimulus(0, 8'hC3, 1'b1);
        expectTx(4'b0001, 8'h5A);
        expectTx(4'b0001, 8'hC3);
        resetDut("long done");
        waitDv(2, 300, "long done");
        waitTxIdle(200, "long done");
        repeat (4) @(negedge i_Clock);
        checkOutput("long done dv count", dvCount, 2);
        doneCycles = 1;

        // Reset while the transmitter shifts data bits of 0x55.
        i_Reset = 1'b1;
        applyStimulus(0, 8'h55, 1'b1);
        applyStimulus(0, 8'h66, 1'b1);
        expectTx(4'b0001, 8'h55);
        resetDut("midframe");
        waitDv(1, 100, "midframe");
        repeat (3 * CLKS_PER_BIT) @(negedge i_Clock);
        checkOutput("midframe tx active before reset", i_Tx_Active, 1);
        i_Reset = 1'b1;
        @(negedge i_Clock);
        checkOutput("midframe grant after reset", o_Grant, 0);
        checkOutput("midframe dv after reset", o_Tx_DV, 0);
        checkOutput("midframe byte after reset", o_Tx_Byte, 0);
        checkOutput("midframe ready after reset", o_Req_Ready, 0);
        i_Reset = 1'b0;
        expectTx(4'b0001, 8'h66);
        sawGrant = 1'b0;
        n = 0;
        while ((i_Tx_Active || i_Tx_Done) && n < 200) begin
            if (o_Grant != 4'b0000) sawGrant = 1'b1;
            @(negedge i_Clock);
            n++;
        end
        checkOutput("midframe no grant while tx busy", sawGrant, 0);
        waitDv(2, 200, "midframe");
        waitTxIdle(200, "midframe");
        checkOutput("midframe dv count", dvCount, 2);

        checkOutput("scoreboard drained", sbQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serial transmitter between NUM_REQ byte-stream requesters.
- Arbitration is round-robin per packet. A granted requester keeps the transmitter until it sends a byte marked last, or until it idles longer than GRANT_TIMEOUT clocks.
- Sequences the transmitter's DV/Active/Done handshake so that each byte is issued only after the previous byte has fully completed.
- Sits between the debug/telemetry message sources and the single UART pin.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- GRANT_TIMEOUT, 1024: clocks a granted requester may sit with no valid byte before it loses the grant; 0 disables the timeout.
- TIMER_W, 16: timeout counter width; must satisfy GRANT_TIMEOUT < 2^TIMER_W.

Ports:
- i_Clock  in  1  system clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Req_Valid  in  NUM_REQ  per-requester byte valid.
- i_Req_Byte  in  8*NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k].
- i_Req_Last  in  NUM_REQ  byte is the final byte of its packet.
- o_Req_Ready  out  NUM_REQ  byte accepted when Ready & Valid are both high.
- o_Grant  out  NUM_REQ  one-hot current owner; all zero when no owner.
- o_Tx_DV  out  1  one-cycle start strobe to the transmitter.
- o_Tx_Byte  out  8  byte to the transmitter; stable from DV until Done.
- i_Tx_Active  in  1  transmitter busy.
- i_Tx_Done  in  1  transmitter complete; may stay high for 1 or more cycles.

Behaviour:
- Reset: all outputs 0; state ARB; round-robin pointer = 0; timer = 0.
- Reset mid-transfer aborts immediately. The byte already in the transmitter still finishes on the line. After reset, state ARB does not issue DV until i_Tx_Active = 0 and i_Tx_Done = 0.
- States:
  - ARB: if any i_Req_Valid is high and the transmitter is idle, grant the first valid requester at or after the pointer, wrapping modulo NUM_REQ. Next state HOLD; o_Grant is registered and valid from the next cycle.
  - HOLD: o_Req_Ready[g] = 1 (combinational from state and grant), so one byte can be accepted per visit.
    - On accept: capture i_Req_Byte[g] into o_Tx_Byte, record the last flag, clear the timer, next state ISSUE.
    - Otherwise increment the timer. When timer = GRANT_TIMEOUT - 1 (and the timeout is enabled), drop the grant, set pointer = g+1, next state ARB.
  - ISSUE: o_Tx_DV = 1 for exactly this cycle; next state WAIT_BUSY. Latency from accept to DV is 1 clock.
  - WAIT_BUSY: wait for i_Tx_Active = 1, then go to WAIT_DONE.
  - WAIT_DONE: wait for i_Tx_Done = 1, then go to WAIT_IDLE.
  - WAIT_IDLE: wait for i_Tx_Done = 0 and i_Tx_Active = 0.
    - If the last flag is set: clear o_Grant, pointer = g+1, next state ARB.
    - Otherwise next state HOLD.
- o_Req_Ready is 0 in every state other than HOLD.
- o_Grant holds steady from HOLD entry until release. The owner changes only in ARB.
- A requester dropping Valid mid-packet keeps the grant, subject to the timeout.
- Simultaneous requests: the rotation guarantees every valid requester is granted within NUM_REQ packets.
- Pointer arithmetic wraps: g = NUM_REQ-1 gives pointer = 0.
- A last byte accepted in the same cycle the timer would expire counts as an accept; the timeout does not fire.
- A single-byte packet (Last asserted on the first byte) is legal.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings: ARB, HOLD, ISSUE, WAIT_BUSY, WAIT_IDLE, WAIT_DONE;
  - UART_BYTE_W = 8.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and an any-request flag.
  - Reusable by future shared-resource blocks.

Test Plan (NUM_REQ=4, GRANT_TIMEOUT=16, uart_tx instantiated with CLKS_PER_BIT=4):
- Single requester: requester 2 sends 0xA5, 0x3C(last) -> o_Grant=0100; DV pulses carry 0xA5 then 0x3C; serial line shows both frames in order; grant drops to 0000 after the second Done clears.
- Contention: all four valid from reset, each sending one 1-byte packet -> grant order 0, 1, 2, 3; no frames interleave; exactly 4 DV pulses.
- Fairness: requester 0 sends back-to-back packets while requester 3 waits -> grant order 0, 3, 0, 3.
- Timeout: requester 1 granted, sends 0x11 (not last), then drops valid -> grant released 16 clocks after entering HOLD; requester 2 (valid) granted next.
- Handshake: DV never asserts while i_Tx_Active=1 or i_Tx_Done=1; o_Tx_Byte stays stable from DV through Done; multi-cycle Done causes no double issue.
- Reset mid-frame: assert i_Reset during the data bits of 0x55 -> outputs 0 the next cycle; no new DV until the transmitter reports idle; then normal arbitration from requester 0.
